// File: rtl/data_sram_responder.sv
// Memory-side responder for the split-transaction data SRAM interface.
// In-order request queue with a programmable head-of-queue response delay.
module data_sram_responder #(
  parameter int unsigned AW         = 12,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned RESP_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  input  logic        addr_hold,
  input  logic        resp_hold
);

  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned DW    = (RESP_DELAY > 1) ? $clog2(RESP_DELAY) : 1;
  localparam int unsigned WORDS = 1 << AW;

  typedef struct packed {
    logic          wr;
    logic [1:0]    size;
    logic [AW-1:0] idx;
    logic [3:0]    wstrb;
    logic [31:0]   wdata;
  } entry_t;

  entry_t        q [DEPTH];
  logic [31:0]   mem [WORDS];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [DW-1:0] cnt;
  entry_t        head_e;
  logic          push;
  logic          pop;
  logic          fire;
  logic          load_cnt;
  logic          unused_ok;

  // No bypass: a full queue refuses even when the head responds this cycle.
  assign addr_ok  = (count < CW'(DEPTH)) & ~addr_hold;
  assign push     = req & addr_ok;
  assign head_e   = q[head];
  // Gated by reset so a discarded store can never reach the array.
  assign fire     = ~reset & (count != '0) & (cnt == '0) & ~resp_hold;
  assign pop      = fire;
  // An entry becomes head when it enters an empty queue or its predecessor pops.
  assign load_cnt = (push & (count == '0)) | (pop & ((count > CW'(1)) | push));

  assign unused_ok = ^{addr[31:AW+2], addr[1:0], head_e.size};

  // Queue control, head countdown and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      cnt     <= '0;
      data_ok <= 1'b0;
      rdata   <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (load_cnt)
        cnt <= DW'(RESP_DELAY - 1);
      else if ((count != '0) && !resp_hold && (cnt != '0))
        cnt <= cnt - DW'(1);
      data_ok <= fire;
      rdata   <= (fire && !head_e.wr) ? mem[head_e.idx] : '0;
    end
  end

  // Queue payload storage.
  always_ff @(posedge clk) begin
    if (push)
      q[tail] <= {wr, size, addr[AW+1:2], wstrb, wdata};
  end

  // Word array; stores commit byte lanes in their response cycle.
  always_ff @(posedge clk) begin
    if (fire && head_e.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (head_e.wstrb[b])
          mem[head_e.idx][8*b +: 8] <= head_e.wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: one instance with RESP_DELAY=1 (a_*),
// one with RESP_DELAY=3 (b_*), both DEPTH=2.
module tb_data_sram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_reset, a_req, a_wr, a_addr_hold, a_resp_hold;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata;
  logic [3:0]  a_wstrb;
  logic        a_addr_ok, a_data_ok;
  logic [31:0] a_rdata;

  logic        b_reset, b_req, b_wr, b_addr_hold, b_resp_hold;
  logic [1:0]  b_size;
  logic [31:0] b_addr, b_wdata;
  logic [3:0]  b_wstrb;
  logic        b_addr_ok, b_data_ok;
  logic [31:0] b_rdata;

  data_sram_responder #(.AW(12), .DEPTH(2), .RESP_DELAY(1)) dut_a (
    .clk(clk), .reset(a_reset), .req(a_req), .wr(a_wr), .size(a_size),
    .addr(a_addr), .wstrb(a_wstrb), .wdata(a_wdata), .addr_ok(a_addr_ok),
    .data_ok(a_data_ok), .rdata(a_rdata), .addr_hold(a_addr_hold),
    .resp_hold(a_resp_hold)
  );

  data_sram_responder #(.AW(12), .DEPTH(2), .RESP_DELAY(3)) dut_b (
    .clk(clk), .reset(b_reset), .req(b_req), .wr(b_wr), .size(b_size),
    .addr(b_addr), .wstrb(b_wstrb), .wdata(b_wdata), .addr_ok(b_addr_ok),
    .data_ok(b_data_ok), .rdata(b_rdata), .addr_hold(b_addr_hold),
    .resp_hold(b_resp_hold)
  );

  logic        op_wr    [8];
  logic [31:0] op_addr  [8];
  logic [31:0] op_wdata [8];
  int          acc_cyc  [8];
  int          rsp_cyc  [8];
  logic [31:0] rsp_data [8];
  int          n_rsp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_set(input logic r, input logic w, input logic [31:0] ad,
                       input logic [31:0] wd, input logic [3:0] st);
    a_req = r; a_wr = w; a_addr = ad; a_wdata = wd; a_wstrb = st;
  endtask

  task automatic b_set(input logic r, input logic w, input logic [31:0] ad,
                       input logic [31:0] wd, input logic [3:0] st);
    b_req = r; b_wr = w; b_addr = ad; b_wdata = wd; b_wstrb = st;
  endtask

  task automatic b_drive(input int i, input int n);
    if (i < n) b_set(1'b1, op_wr[i], op_addr[i], op_wdata[i], 4'hF);
    else       b_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // Holds req while ops remain, logging accept and response cycles.
  task automatic run_b(input int n);
    int   n_iss = 0;
    int   cyc   = 0;
    logic acc;
    n_rsp = 0;
    b_drive(0, n);
    #1;
    while (n_rsp < n && cyc < 100) begin
      acc = b_req & b_addr_ok;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        acc_cyc[n_iss] = cyc;
        n_iss++;
      end
      if (b_data_ok) begin
        rsp_cyc[n_rsp]  = cyc;
        rsp_data[n_rsp] = b_rdata;
        n_rsp++;
      end
      b_drive(n_iss, n);
      #1;
    end
    chk("b_all_responses", 32'(n_rsp), 32'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    a_reset = 1'b1; a_addr_hold = 1'b0; a_resp_hold = 1'b0; a_size = 2'd2;
    b_reset = 1'b1; b_addr_hold = 1'b0; b_resp_hold = 1'b0; b_size = 2'd2;
    a_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    b_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
    chk("rst_data_ok", 32'(a_data_ok), 32'd0);
    chk("rst_rdata", a_rdata, 32'h0);
    chk("rst_addr_ok", 32'(a_addr_ok), 32'd1);
    a_reset = 1'b0;
    b_reset = 1'b0;

    // Full store then load, back to back.
    a_set(1'b1, 1'b1, 32'h10, 32'h11223344, 4'hF);
    #1 chk("t1_addr_ok", 32'(a_addr_ok), 32'd1);
    tick();
    chk("t1_idle", 32'(a_data_ok), 32'd0);
    a_set(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    tick();
    chk("t1_st_data_ok", 32'(a_data_ok), 32'd1);
    chk("t1_st_rdata", a_rdata, 32'h0);
    a_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    chk("t1_ld_data_ok", 32'(a_data_ok), 32'd1);
    chk("t1_ld_rdata", a_rdata, 32'h11223344);
    tick();
    chk("t1_done_data_ok", 32'(a_data_ok), 32'd0);
    chk("t1_done_rdata", a_rdata, 32'h0);

    // Single-lane partial store.
    a_set(1'b1, 1'b1, 32'h10, 32'h00AA0000, 4'h4);
    tick();
    a_set(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    tick();
    chk("t2_st_data_ok", 32'(a_data_ok), 32'd1);
    a_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    chk("t2_ld_data_ok", 32'(a_data_ok), 32'd1);
    chk("t2_ld_rdata", a_rdata, 32'h11AA3344);
    tick();
    chk("t2_done", 32'(a_data_ok), 32'd0);

    // addr_hold blocks acceptance while req is high.
    a_addr_hold = 1'b1;
    a_set(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("t6_held_addr_ok", 32'(a_addr_ok), 32'd0);
      tick();
      chk("t6_held_data_ok", 32'(a_data_ok), 32'd0);
    end
    a_addr_hold = 1'b0;
    #1 chk("t6_release_addr_ok", 32'(a_addr_ok), 32'd1);
    tick();
    a_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("t6_accept_cycle", 32'(a_data_ok), 32'd0);
    tick();
    chk("t6_data_ok", 32'(a_data_ok), 32'd1);
    chk("t6_rdata", a_rdata, 32'h11AA3344);
    tick();
    chk("t6_done", 32'(a_data_ok), 32'd0);

    // Known values at 0x20 / 0x24.
    a_set(1'b1, 1'b1, 32'h20, 32'hCAFE0020, 4'hF);
    tick();
    a_set(1'b1, 1'b1, 32'h24, 32'hBEEF0024, 4'hF);
    tick();
    a_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();

    // Two stores outstanding when reset hits: they must be discarded.
    a_resp_hold = 1'b1;
    a_set(1'b1, 1'b1, 32'h20, 32'hDEAD0000, 4'hF);
    tick();
    a_set(1'b1, 1'b1, 32'h24, 32'hDEAD0004, 4'hF);
    tick();
    a_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1 chk("t5_full_addr_ok", 32'(a_addr_ok), 32'd0);
    chk("t5_held_data_ok", 32'(a_data_ok), 32'd0);
    a_reset = 1'b1;
    a_resp_hold = 1'b0;
    tick();
    a_reset = 1'b0;
    chk("t5_rst_data_ok", 32'(a_data_ok), 32'd0);
    #1 chk("t5_post_rst_addr_ok", 32'(a_addr_ok), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_data_ok", 32'(a_data_ok), 32'd0);
    end
    a_set(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    tick();
    a_set(1'b1, 1'b0, 32'h24, 32'h0, 4'h0);
    tick();
    chk("t5_ld20_data_ok", 32'(a_data_ok), 32'd1);
    chk("t5_ld20_rdata", a_rdata, 32'hCAFE0020);
    a_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    chk("t5_ld24_data_ok", 32'(a_data_ok), 32'd1);
    chk("t5_ld24_rdata", a_rdata, 32'hBEEF0024);
    tick();
    chk("t5_done", 32'(a_data_ok), 32'd0);

    // RESP_DELAY=3: preload four words, then four loads with req held high.
    for (int i = 0; i < 4; i++) begin
      op_wr[i]    = 1'b1;
      op_addr[i]  = 32'h40 + 32'(4 * i);
      op_wdata[i] = {8'hA0 + 8'(16 * i), 8'hA0 + 8'(16 * i), 16'(i + 1)};
    end
    run_b(4);
    chk("b_st_rdata", rsp_data[0], 32'h0);
    for (int i = 0; i < 4; i++) op_wr[i] = 1'b0;
    run_b(4);
    chk("b_acc0", 32'(acc_cyc[0]), 32'd1);
    chk("b_acc1", 32'(acc_cyc[1]), 32'd2);
    chk("b_acc2_after_full", 32'(acc_cyc[2]), 32'd5);
    chk("b_acc3", 32'(acc_cyc[3]), 32'd8);
    chk("b_rsp0_cyc", 32'(rsp_cyc[0]), 32'd4);
    chk("b_rsp1_cyc", 32'(rsp_cyc[1]), 32'd7);
    chk("b_rsp2_cyc", 32'(rsp_cyc[2]), 32'd10);
    chk("b_rsp3_cyc", 32'(rsp_cyc[3]), 32'd13);
    chk("b_rsp0_data", rsp_data[0], 32'hA0A00001);
    chk("b_rsp1_data", rsp_data[1], 32'hB0B00002);
    chk("b_rsp2_data", rsp_data[2], 32'hC0C00003);
    chk("b_rsp3_data", rsp_data[3], 32'hD0D00004);

    // Full queue with resp_hold for 5 cycles pushes the head out by 5.
    tick();
    b_set(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    tick();
    b_set(1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
    tick();
    b_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    b_resp_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("t4_hold_addr_ok", 32'(b_addr_ok), 32'd0);
      tick();
      chk("t4_hold_data_ok", 32'(b_data_ok), 32'd0);
    end
    b_resp_hold = 1'b0;
    #1 chk("t4_release_addr_ok", 32'(b_addr_ok), 32'd0);
    tick();
    chk("t4_countdown", 32'(b_data_ok), 32'd0);
    tick();
    chk("t4_head_data_ok", 32'(b_data_ok), 32'd1);
    chk("t4_head_rdata", b_rdata, 32'hA0A00001);
    #1 chk("t4_slot_free", 32'(b_addr_ok), 32'd1);
    tick();
    chk("t4_gap1", 32'(b_data_ok), 32'd0);
    tick();
    chk("t4_gap2", 32'(b_data_ok), 32'd0);
    tick();
    chk("t4_next_data_ok", 32'(b_data_ok), 32'd1);
    chk("t4_next_rdata", b_rdata, 32'hB0B00002);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
